// File: rtl/fifo_width_converter.sv
// Synchronous FIFO that stores narrow units and converts between a wide and a narrow port.
// Occupancy is tracked in narrow units, so the flags are exact for both port widths.
module fifo_width_converter #(
  parameter int NARROW_WIDTH = 8,
  parameter int RATIO        = 2,
  parameter int ADDR_WIDTH   = 4,
  parameter bit WIDE_WRITE   = 1'b1,
  parameter int ALMOST_FULL  = 12
) (
  input  logic                                                clk_i,
  input  logic                                                reset_ni,
  input  logic                                                write_i,
  input  logic [NARROW_WIDTH*(WIDE_WRITE ? RATIO : 1)-1:0]    write_data_i,
  input  logic                                                read_i,
  output logic [NARROW_WIDTH*(WIDE_WRITE ? 1 : RATIO)-1:0]    read_data_o,
  output logic                                                full_o,
  output logic                                                empty_o,
  output logic                                                almost_full_o,
  output logic [ADDR_WIDTH:0]                                 count_o,
  output logic                                                overflow_o,
  output logic                                                underflow_o
);

  localparam int IN_U  = WIDE_WRITE ? RATIO : 1;
  localparam int OUT_U = WIDE_WRITE ? 1 : RATIO;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [CW-1:0] IN_STEP    = CW'(IN_U);
  localparam logic [CW-1:0] OUT_STEP   = CW'(OUT_U);
  localparam logic [CW-1:0] FULL_LIMIT = CW'(DEPTH - IN_U);
  localparam logic [31:0]   AF_LEVEL   = ALMOST_FULL;

  logic [NARROW_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   r_wptr;
  logic [ADDR_WIDTH-1:0]   r_rptr;
  logic [CW-1:0]           r_count;
  logic                    r_overflow;
  logic                    r_underflow;

  logic                                              w_full;
  logic                                              w_empty;
  logic                                              w_wr_acc;
  logic                                              w_rd_acc;
  logic [NARROW_WIDTH*(WIDE_WRITE ? 1 : RATIO)-1:0]  w_rdata;

  // Flags look only at the registered count, so a same-cycle read never frees room for a write.
  assign w_full   = r_count > FULL_LIMIT;
  assign w_empty  = r_count < OUT_STEP;
  assign w_wr_acc = write_i && !w_full;
  assign w_rd_acc = read_i && !w_empty;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + ADDR_WIDTH'(IN_U);
      if (w_rd_acc) r_rptr <= r_rptr + ADDR_WIDTH'(OUT_U);
      r_count     <= r_count + (w_wr_acc ? IN_STEP : '0) - (w_rd_acc ? OUT_STEP : '0);
      r_overflow  <= write_i && w_full;
      r_underflow <= read_i && w_empty;
    end
  end

  // Storage is deliberately not reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (w_wr_acc) begin
      for (int i = 0; i < IN_U; i++) begin
        r_mem[r_wptr + ADDR_WIDTH'(i)] <= write_data_i[i*NARROW_WIDTH +: NARROW_WIDTH];
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < OUT_U; i++) begin
      w_rdata[i*NARROW_WIDTH +: NARROW_WIDTH] = r_mem[r_rptr + ADDR_WIDTH'(i)];
    end
  end

  assign read_data_o   = w_rdata;
  assign full_o        = w_full;
  assign empty_o       = w_empty;
  assign almost_full_o = 32'(r_count) >= AF_LEVEL;
  assign count_o       = r_count;
  assign overflow_o    = r_overflow;
  assign underflow_o   = r_underflow;

endmodule

// File: tb/tb_fifo_width_converter.sv
// Bench for fifo_width_converter: one wide-write and one narrow-write instance,
// each compared against a byte-queue model of the FIFO.
module tb_fifo_width_converter;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rstN;

  logic        aWr, aRd;
  logic [15:0] aWd;
  logic [7:0]  aRdata;
  logic        aFull, aEmpty, aAf, aOvf, aUnf;
  logic [4:0]  aCount;

  logic        bWr, bRd;
  logic [7:0]  bWd;
  logic [15:0] bRdata;
  logic        bFull, bEmpty, bAf, bOvf, bUnf;
  logic [4:0]  bCount;

  logic [7:0]  qa[$];
  logic [7:0]  qb[$];
  int          total = 0;
  int          bad = 0;

  fifo_width_converter #(
    .NARROW_WIDTH(8), .RATIO(2), .ADDR_WIDTH(4), .WIDE_WRITE(1'b1), .ALMOST_FULL(12)
  ) dutA (
    .clk_i(clk), .reset_ni(rstN), .write_i(aWr), .write_data_i(aWd), .read_i(aRd),
    .read_data_o(aRdata), .full_o(aFull), .empty_o(aEmpty), .almost_full_o(aAf),
    .count_o(aCount), .overflow_o(aOvf), .underflow_o(aUnf)
  );

  fifo_width_converter #(
    .NARROW_WIDTH(8), .RATIO(2), .ADDR_WIDTH(4), .WIDE_WRITE(1'b0), .ALMOST_FULL(12)
  ) dutB (
    .clk_i(clk), .reset_ni(rstN), .write_i(bWr), .write_data_i(bWd), .read_i(bRd),
    .read_data_o(bRdata), .full_o(bFull), .empty_o(bEmpty), .almost_full_o(bAf),
    .count_o(bCount), .overflow_o(bOvf), .underflow_o(bUnf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of the wide-write instance; the head byte is checked before it is popped.
  task automatic applyStimulusA(input logic w, input logic [15:0] d, input logic r);
    logic fullPre, emptyPre;
    fullPre  = (DEPTH - qa.size()) < 2;
    emptyPre = qa.size() < 1;
    if (!emptyPre) checkOutput("A.rdata", 32'(aRdata), 32'(qa[0]));
    aWr = w; aWd = d; aRd = r;
    @(posedge clk);
    #1;
    aWr = 1'b0; aRd = 1'b0;
    if (r && !emptyPre) void'(qa.pop_front());
    if (w && !fullPre) begin
      qa.push_back(d[7:0]);
      qa.push_back(d[15:8]);
    end
    checkOutput("A.count", 32'(aCount), 32'(qa.size()));
    checkOutput("A.empty", 32'(aEmpty), 32'(qa.size() < 1));
    checkOutput("A.full", 32'(aFull), 32'((DEPTH - qa.size()) < 2));
    checkOutput("A.afull", 32'(aAf), 32'(qa.size() >= 12));
    checkOutput("A.ovf", 32'(aOvf), 32'(w && fullPre));
    checkOutput("A.unf", 32'(aUnf), 32'(r && emptyPre));
  endtask

  // One clock of the narrow-write instance; a read word is the two oldest bytes.
  task automatic applyStimulusB(input logic w, input logic [7:0] d, input logic r);
    logic fullPre, emptyPre;
    fullPre  = (DEPTH - qb.size()) < 1;
    emptyPre = qb.size() < 2;
    if (!emptyPre) checkOutput("B.rdata", 32'(bRdata), 32'({qb[1], qb[0]}));
    bWr = w; bWd = d; bRd = r;
    @(posedge clk);
    #1;
    bWr = 1'b0; bRd = 1'b0;
    if (r && !emptyPre) begin
      void'(qb.pop_front());
      void'(qb.pop_front());
    end
    if (w && !fullPre) qb.push_back(d);
    checkOutput("B.count", 32'(bCount), 32'(qb.size()));
    checkOutput("B.empty", 32'(bEmpty), 32'(qb.size() < 2));
    checkOutput("B.full", 32'(bFull), 32'(qb.size() >= DEPTH));
    checkOutput("B.afull", 32'(bAf), 32'(qb.size() >= 12));
    checkOutput("B.ovf", 32'(bOvf), 32'(w && fullPre));
    checkOutput("B.unf", 32'(bUnf), 32'(r && emptyPre));
  endtask

  initial begin
    rstN = 1'b0;
    aWr = 1'b0; aRd = 1'b0; aWd = '0;
    bWr = 1'b0; bRd = 1'b0; bWd = '0;

    // Reset state, then idle.
    #11;
    checkOutput("rst.A.count", 32'(aCount), 0);
    checkOutput("rst.A.empty", 32'(aEmpty), 1);
    checkOutput("rst.A.full", 32'(aFull), 0);
    checkOutput("rst.B.empty", 32'(bEmpty), 1);
    #1 rstN = 1'b1;
    repeat (3) applyStimulusA(1'b0, '0, 1'b0);
    applyStimulusB(1'b0, '0, 1'b0);

    // Two wide writes read back byte by byte, oldest byte first.
    applyStimulusA(1'b1, 16'hBBAA, 1'b0);
    applyStimulusA(1'b1, 16'hDDCC, 1'b0);
    checkOutput("T2.count4", 32'(aCount), 4);
    checkOutput("T2.rd0", 32'(aRdata), 32'h AA);
    applyStimulusA(1'b0, '0, 1'b1);
    checkOutput("T2.count3", 32'(aCount), 3);
    checkOutput("T2.rd1", 32'(aRdata), 32'h BB);
    applyStimulusA(1'b0, '0, 1'b1);
    checkOutput("T2.rd2", 32'(aRdata), 32'h CC);
    applyStimulusA(1'b0, '0, 1'b1);
    checkOutput("T2.rd3", 32'(aRdata), 32'h DD);
    applyStimulusA(1'b0, '0, 1'b1);
    checkOutput("T2.count0", 32'(aCount), 0);
    checkOutput("T2.empty", 32'(aEmpty), 1);

    // Asynchronous reset in the middle of a fill, checked between clock edges.
    for (int i = 0; i < 3; i++) applyStimulusA(1'b1, 16'($urandom), 1'b0);
    applyStimulusB(1'b1, 8'h5A, 1'b0);
    rstN = 1'b0;
    #2;
    checkOutput("arst.A.count", 32'(aCount), 0);
    checkOutput("arst.A.empty", 32'(aEmpty), 1);
    checkOutput("arst.A.full", 32'(aFull), 0);
    checkOutput("arst.A.afull", 32'(aAf), 0);
    checkOutput("arst.A.ovf", 32'(aOvf), 0);
    checkOutput("arst.A.unf", 32'(aUnf), 0);
    checkOutput("arst.B.count", 32'(bCount), 0);
    qa.delete();
    qb.delete();
    #2 rstN = 1'b1;

    // Fill to full, overflow, drain completely, underflow.
    for (int i = 0; i < 8; i++) applyStimulusA(1'b1, 16'($urandom), 1'b0);
    checkOutput("T3.count16", 32'(aCount), 16);
    checkOutput("T3.full", 32'(aFull), 1);
    applyStimulusA(1'b1, 16'hFFFF, 1'b0);
    checkOutput("T3.ovf", 32'(aOvf), 1);
    checkOutput("T3.stay16", 32'(aCount), 16);
    for (int i = 0; i < 16; i++) applyStimulusA(1'b0, '0, 1'b1);
    applyStimulusA(1'b0, '0, 1'b1);
    checkOutput("T3.unf", 32'(aUnf), 1);

    // At count 15 a combined request: the write bounces, the read goes through.
    for (int i = 0; i < 8; i++) applyStimulusA(1'b1, 16'($urandom), 1'b0);
    applyStimulusA(1'b0, '0, 1'b1);
    checkOutput("T4.count15", 32'(aCount), 15);
    applyStimulusA(1'b1, 16'h1234, 1'b1);
    checkOutput("T4.ovf", 32'(aOvf), 1);
    checkOutput("T4.count14", 32'(aCount), 14);
    for (int i = 0; i < 14; i++) applyStimulusA(1'b0, '0, 1'b1);

    // Narrow writes assembled into a wide read word; a lone byte stays held.
    applyStimulusB(1'b1, 8'hAA, 1'b0);
    checkOutput("T5.emptyAA", 32'(bEmpty), 1);
    applyStimulusB(1'b1, 8'hBB, 1'b0);
    checkOutput("T5.emptyBB", 32'(bEmpty), 0);
    checkOutput("T5.word", 32'(bRdata), 32'h BBAA);
    applyStimulusB(1'b1, 8'hCC, 1'b0);
    applyStimulusB(1'b0, '0, 1'b1);
    checkOutput("T5.count1", 32'(bCount), 1);
    checkOutput("T5.empty", 32'(bEmpty), 1);
    applyStimulusB(1'b1, 8'hDD, 1'b0);
    applyStimulusB(1'b0, '0, 1'b1);

    // Streaming through the pointer wrap; writes on alternate cycles because a wide
    // write every cycle would outpace the narrow reader.
    applyStimulusA(1'b1, 16'h0100, 1'b0);
    for (int k = 0; k < 40; k++) begin
      applyStimulusA(k[0], 16'({8'(2*k+3), 8'(2*k+2)}), 1'b1);
      checkOutput("T6.range", 32'(aCount >= 5'd1 && aCount <= 5'd2), 1);
    end

    // Randomized traffic on both instances.
    for (int i = 0; i < 250; i++) begin
      applyStimulusA(1'($urandom), 16'($urandom), 1'($urandom));
      applyStimulusB(($urandom_range(0, 9) < 6), 8'($urandom), ($urandom_range(0, 9) < 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
